bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter. It is the reverse of the random-number

---
 rtl/bcd_to_bin.sv | 164 ++++++++++++++++
 tb/tb_bcd_to_bin.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin
//  Purpose  : Sequential packed-BCD to binary converter using reverse
//             double-dabble. Each clock shifts the work register right by
//             one bit, then subtracts 3 from every BCD digit that is 8 or
//             more. A start/busy/done handshake frames each conversion.
//  Options  : BCD_CHECK_EN - when defined, invalid digits (>9) are detected
//             at capture. The SHIFT phase is skipped and the result is err=1,
//             bin_out=0. When undefined, err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  rst,      // asynchronous, active-low
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int                 BCD_W    = 4 * DIGITS;
   localparam int                 WORK_W   = BCD_W + BIN_W;
   localparam int                 CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WORK_W-1:0]   work_q, work_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [BIN_W-1:0]    bin_out_q, bin_out_d;

   // One right shift of {bcd, bin}; the correction applies to the BCD half only
   logic [WORK_W-1:0]   shifted;
   logic [BCD_W-1:0]    bcd_corr;

   assign shifted = work_q >> 1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         // A digit that picked up the bit shifted down from the next digit
         // (value >= 8) has gained 8 instead of 5, so take 3 back out.
         assign bcd_corr[4*i +: 4] = shifted[BIN_W + 4*i + 3]
                                   ? (shifted[BIN_W + 4*i +: 4] - 4'd3)
                                   : shifted[BIN_W + 4*i +: 4];
      end
   endgenerate

`ifdef BCD_CHECK_EN
   logic                err_q, err_d;
   logic [DIGITS-1:0]   digit_bad;

   generate
      for (genvar j = 0; j < DIGITS; j++) begin : g_check
         assign digit_bad[j] = (bcd_in[4*j +: 4] > 4'd9);
      end
   endgenerate
`endif

   // Next-state and datapath computation for every register
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bin_out_d = bin_out_q;
`ifdef BCD_CHECK_EN
      err_d     = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               work_d = {bcd_in, {BIN_W{1'b0}}};
               cnt_d  = '0;
`ifdef BCD_CHECK_EN
               if (|digit_bad) begin
                  // Invalid operand: report immediately without shifting
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  bin_out_d = '0;
                  err_d     = 1'b1;
               end else begin
                  state_d = ST_SHIFT;
                  busy_d  = 1'b1;
                  err_d   = 1'b0;
               end
`else
               state_d = ST_SHIFT;
               busy_d  = 1'b1;
`endif
            end
         end
         ST_SHIFT: begin
            work_d = {bcd_corr, shifted[BIN_W-1:0]};
            if (cnt_q == CNT_LAST) begin
               // Last step: the binary half of the shifted word is the result
               state_d   = ST_DONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               bin_out_d = shifted[BIN_W-1:0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         work_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_out_q <= '0;
`ifdef BCD_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bin_out_q <= bin_out_d;
`ifdef BCD_CHECK_EN
         err_q     <= err_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_out_q;
`ifdef BCD_CHECK_EN
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_bin
//  Purpose  : Self-checking bench for bcd_to_bin. Expected results come from
//             plain decimal arithmetic on the BCD digits; handshake timing is
//             checked against the documented latencies.
//  Options  : BCD_CHECK_EN - enables the invalid-digit scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

   localparam int DIGITS = 2;
   localparam int BIN_W  = 7;
`ifdef BCD_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [4*DIGITS-1:0]  bcd_in;
   logic                 busy;
   logic                 done;
   logic [BIN_W-1:0]     bin_out;
   logic                 err;

   int checks;
   int errors;

   bcd_to_bin #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: decimal value of the packed BCD digits
   function automatic int bcd_value(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit bcd_invalid(input logic [7:0] b);
      return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
   endfunction

   // Run one conversion starting from an IDLE cycle (called at posedge+1).
   // poke_at >= 0 raises start for one edge while the job is running.
   task automatic do_conv(input string tag, input logic [7:0] bcd,
                          input int poke_at, input bit check_bin);
      int  lat;
      int  busy_cnt;
      bit  bad;
      int  exp_lat;
      int  exp_bin;
      bad     = bcd_invalid(bcd) && CHECK_EN;
      exp_lat = bad ? 0 : BIN_W;
      exp_bin = bad ? 0 : bcd_value(bcd);
      start   = 1'b1;
      bcd_in  = bcd;
      @(posedge clk); #1;
      start   = 1'b0;
      bcd_in  = 8'($urandom);        // must not disturb the captured operand
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 30) begin
         if (busy) busy_cnt++;
         start = (lat == poke_at);
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy_cycles"}, busy_cnt, exp_lat);
      check({tag, " busy_at_done"}, busy, 0);
      if (check_bin) check({tag, " bin_out"}, bin_out, exp_bin);
      check({tag, " err"}, err, bad);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, done, 0);
      if (check_bin) check({tag, " bin_out_held"}, bin_out, exp_bin);
   endtask

   initial begin
      int         pulses;
      int         last;
      logic [7:0] r;
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      #3;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset bin_out", bin_out, 0);
      check("reset err", err, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      do_conv("t1_99", 8'h99, -1, 1'b1);
      do_conv("t2_00", 8'h00, -1, 1'b1);
      do_conv("t2_42", 8'h42, -1, 1'b1);

      // Start pulse during a running job is dropped
      do_conv("t3_57", 8'h57, 3, 1'b1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) pulses++;
         @(posedge clk); #1;
      end
      check("t3 extra_done", pulses, 0);

      // Asynchronous reset in the middle of a conversion
      start  = 1'b1;
      bcd_in = 8'h63;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (3) @(posedge clk);
      #5;
      rst = 1'b0;
      #1;
      check("t4 rst busy", busy, 0);
      check("t4 rst done", done, 0);
      check("t4 rst bin_out", bin_out, 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) pulses++;
         @(posedge clk); #1;
      end
      check("t4 no_done_in_reset", pulses, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      do_conv("t4_12", 8'h12, -1, 1'b1);

      // Invalid digits
      do_conv("t5_A5", 8'hA5, -1, CHECK_EN);
      do_conv("t5_05", 8'h05, -1, 1'b1);

      // start held high: back-to-back conversions every BIN_W+2 cycles
      start  = 1'b1;
      bcd_in = 8'h10;
      pulses = 0;
      last   = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            check("t6 bin_out", bin_out, 10);
            if (last >= 0) check("t6 period", i - last, BIN_W + 2);
            last = i;
            pulses++;
         end
      end
      check("t6 pulse_count", pulses >= 4, 1);
      start = 1'b0;
      repeat (BIN_W + 3) @(posedge clk);
      #1;

      // Randomized valid operands against the decimal model
      for (int n = 0; n < 25; n++) begin
         r = {4'($urandom_range(9)), 4'($urandom_range(9))};
         do_conv($sformatf("rnd%0d_%02h", n, r), r, -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
